// File: rtl/shade_motor_ctrl.sv
// Window-shade motor sequencer: debounces the requested level, then steps the
// shade one level per STEP_CYCLES toward it with registered motor controls.
module shade_motor_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int STEP_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] target,
    output logic [3:0] position,
    output logic       motor_up,
    output logic       motor_down,
    output logic       step_pulse,
    output logic       busy,
    output logic       done
);

    // state     | meaning
    // IDLE      | shade at rest, watching for a new target
    // SETTLE    | target must hold steady for SETTLE_CYCLES before motion
    // MOVE_UP   | stepping toward closed (position increasing)
    // MOVE_DOWN | stepping toward open (position decreasing)
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETTLE    = 2'd1,
        MOVE_UP   = 2'd2,
        MOVE_DOWN = 2'd3
    } state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] STEP_LAST   = PW'(STEP_CYCLES - 1);

    state_t          state;
    logic [3:0]      tgt_q;
    logic [SW-1:0]   settle_cnt;
    logic [PW-1:0]   step_cnt;
    logic [3:0]      pos_next;

    // Only consumed in the move states, so the wrap in other states is harmless.
    always_comb begin
        pos_next = (state == MOVE_UP) ? position + 4'd1 : position - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            position   <= 4'd0;
            tgt_q      <= 4'd0;
            settle_cnt <= '0;
            step_cnt   <= '0;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && (target != position)) begin
                        state      <= SETTLE;
                        tgt_q      <= target;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (!enable) begin
                        state      <= IDLE;
                        settle_cnt <= '0;
                        busy       <= 1'b0;
                    end else if (target != tgt_q) begin
                        tgt_q      <= target;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        step_cnt   <= '0;
                        if (tgt_q > position) begin
                            state    <= MOVE_UP;
                            motor_up <= 1'b1;
                        end else if (tgt_q < position) begin
                            state      <= MOVE_DOWN;
                            motor_down <= 1'b1;
                        end else begin
                            // Target glitched away and back: nothing to do, no done.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                MOVE_UP, MOVE_DOWN: begin
                    if (!enable) begin
                        state      <= IDLE;
                        step_cnt   <= '0;
                        motor_up   <= 1'b0;
                        motor_down <= 1'b0;
                        busy       <= 1'b0;
                    end else if (step_cnt == STEP_LAST) begin
                        step_cnt   <= '0;
                        position   <= pos_next;
                        step_pulse <= 1'b1;
                        if (pos_next == tgt_q) begin
                            state      <= IDLE;
                            motor_up   <= 1'b0;
                            motor_down <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else if (target != tgt_q) begin
                            // Retarget is only honoured at a step boundary.
                            state      <= SETTLE;
                            tgt_q      <= target;
                            settle_cnt <= '0;
                            motor_up   <= 1'b0;
                            motor_down <= 1'b0;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    motor_up   <= 1'b0;
                    motor_down <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shade_motor_ctrl.sv
// Scoreboard bench for shade_motor_ctrl: expected output vectors are queued
// with the cycle they are due at, and the monitor compares on the falling edge.
module tb_shade_motor_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] target = 4'd0;
    logic [3:0] position;
    logic       motor_up, motor_down, step_pulse, busy, done;

    shade_motor_ctrl #(.SETTLE_CYCLES(4), .STEP_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .target    (target),
        .position  (position),
        .motor_up  (motor_up),
        .motor_down(motor_down),
        .step_pulse(step_pulse),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [8:0] v;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // flags = {motor_up, motor_down, step_pulse, busy, done}
    task automatic ex(input int c, input string tag, input logic [3:0] p, input logic [4:0] flags);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.v   = {p, flags};
        sb.push_back(e);
    endtask

    function automatic logic [8:0] obs();
        return {position, motor_up, motor_down, step_pulse, busy, done};
    endfunction

    always @(negedge clk) begin
        if (!rst) chk("mutex", 32'(motor_up & motor_down), 32'd0);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, 32'(obs()), 32'(e.v));
        end
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        #1;
        chk(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        sync();
        rst    = 1'b1;
        enable = 1'b0;
        target = 4'd0;
        #1;
        chk("reset_vec", 32'(obs()), 32'd0);
        repeat (2) sync();
        rst = 1'b0;
        sync();
    endtask

    int k, k2;

    initial begin
        #2;
        chk("por_vec", 32'(obs()), 32'd0);

        // 0 -> 3 upward move
        do_reset();
        k = cyc + 1; enable = 1'b1; target = 4'd3;
        ex(k,      "up_busy",    4'd0, 5'b00010);
        ex(k + 3,  "up_settle",  4'd0, 5'b00010);
        ex(k + 4,  "up_motor",   4'd0, 5'b10010);
        ex(k + 12, "up_step1",   4'd1, 5'b10110);
        ex(k + 13, "up_mid",     4'd1, 5'b10010);
        ex(k + 20, "up_step2",   4'd2, 5'b10110);
        ex(k + 28, "up_done",    4'd3, 5'b00101);
        ex(k + 29, "up_idle",    4'd3, 5'b00000);
        drain("drain_up");

        // 3 -> 1 downward move
        k = cyc + 1; target = 4'd1;
        ex(k,      "dn_busy",    4'd3, 5'b00010);
        ex(k + 4,  "dn_motor",   4'd3, 5'b01010);
        ex(k + 12, "dn_step1",   4'd2, 5'b01110);
        ex(k + 20, "dn_done",    4'd1, 5'b00101);
        ex(k + 21, "dn_idle",    4'd1, 5'b00000);
        drain("drain_dn");

        // Glitch rejection
        do_reset();
        k = cyc + 1; enable = 1'b1; target = 4'd5;
        ex(k,      "gl_busy",    4'd0, 5'b00010);
        ex(k + 4,  "gl_nomotor", 4'd0, 5'b00010);
        ex(k + 5,  "gl_settle",  4'd0, 5'b00010);
        ex(k + 6,  "gl_idle",    4'd0, 5'b00000);
        ex(k + 14, "gl_quiet",   4'd0, 5'b00000);
        wait_until(k + 1);
        target = 4'd0;
        drain("drain_gl");

        // Retarget mid-step to the next level: lands there, no done
        do_reset();
        k = cyc + 1; enable = 1'b1; target = 4'd10;
        ex(k,      "rta_busy",   4'd0, 5'b00010);
        ex(k + 12, "rta_step1",  4'd1, 5'b10110);
        ex(k + 16, "rta_nabort", 4'd1, 5'b10010);
        ex(k + 20, "rta_step2",  4'd2, 5'b00110);
        ex(k + 23, "rta_settle", 4'd2, 5'b00010);
        ex(k + 24, "rta_idle",   4'd2, 5'b00000);
        ex(k + 30, "rta_quiet",  4'd2, 5'b00000);
        wait_until(k + 15);
        target = 4'd2;
        drain("drain_rta");

        // Retarget mid-step back to 0: reverses after settle
        do_reset();
        k = cyc + 1; enable = 1'b1; target = 4'd10;
        ex(k + 12, "rtb_step1",  4'd1, 5'b10110);
        ex(k + 20, "rtb_step2",  4'd2, 5'b00110);
        ex(k + 24, "rtb_down",   4'd2, 5'b01010);
        ex(k + 32, "rtb_step3",  4'd1, 5'b01110);
        ex(k + 40, "rtb_done",   4'd0, 5'b00101);
        ex(k + 41, "rtb_idle",   4'd0, 5'b00000);
        wait_until(k + 15);
        target = 4'd0;
        drain("drain_rtb");

        // enable dropped mid-step, then resumed
        do_reset();
        k = cyc + 1; enable = 1'b1; target = 4'd8;
        ex(k + 36, "en_pos4",    4'd4, 5'b10110);
        ex(k + 39, "en_mid",     4'd4, 5'b10010);
        ex(k + 40, "en_off",     4'd4, 5'b00000);
        ex(k + 42, "en_hold",    4'd4, 5'b00000);
        wait_until(k + 39);
        enable = 1'b0;
        wait_until(k + 42);
        enable = 1'b1;
        k2 = k + 43;
        ex(k2,      "en_busy",   4'd4, 5'b00010);
        ex(k2 + 4,  "en_motor",  4'd4, 5'b10010);
        ex(k2 + 12, "en_step5",  4'd5, 5'b10110);
        ex(k2 + 36, "en_done",   4'd8, 5'b00101);
        drain("drain_en");

        // Async reset mid-move, then a full 7-step move
        do_reset();
        k = cyc + 1; enable = 1'b1; target = 4'd10;
        ex(k,      "rs_busy",    4'd0, 5'b00010);
        ex(k + 60, "rs_pos7",    4'd7, 5'b10110);
        ex(k + 62, "rs_mid",     4'd7, 5'b10010);
        wait_until(k + 63);
        rst = 1'b1;
        #1;
        chk("rs_async", 32'(obs()), 32'd0);
        repeat (2) sync();
        rst = 1'b0; target = 4'd7; enable = 1'b1;
        k = cyc + 1;
        ex(k,      "rs2_busy",   4'd0, 5'b00010);
        ex(k + 4,  "rs2_motor",  4'd0, 5'b10010);
        ex(k + 59, "rs2_pos6",   4'd6, 5'b10010);
        ex(k + 60, "rs2_done",   4'd7, 5'b00101);
        drain("drain_rs");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
